// File: rtl/miriscv_data_bus.sv
// Data-side interconnect: decodes core accesses onto N slave windows, one transaction at a time.
// Define MIRISCV_BUS_ERR_LATCH_EN to add the last-fault address and saturating fault counter.
module miriscv_data_bus #(
    parameter int unsigned              N_SLAVES       = 2,
    parameter logic [N_SLAVES*32-1:0]   SLAVE_BASE     = {32'h8000_2000, 32'h8000_0000},
    parameter logic [N_SLAVES*32-1:0]   SLAVE_MASK     = {32'hFFFF_FF00, 32'hFFFF_F000},
    parameter int unsigned              TIMEOUT_CYCLES = 16,
    parameter logic [31:0]              DEF_RDATA      = 32'h0000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic [31:0]             addr_i,
    input  logic [31:0]             wdata_i,
    output logic                    stall_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [31:0]             rdata_o,
    output logic [N_SLAVES-1:0]     s_req_o,
    output logic                    s_we_o,
    output logic [3:0]              s_be_o,
    output logic [31:0]             s_addr_o,
    output logic [31:0]             s_wdata_o,
    input  logic [N_SLAVES*32-1:0]  s_rdata_i,
    input  logic [N_SLAVES-1:0]     s_ack_i,
    output logic [31:0]             err_addr_o,
    output logic [7:0]              err_cnt_o
);

    localparam int unsigned IdxW        = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned CntW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TimeoutLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            hit;
    logic [IdxW-1:0] hit_idx;
    logic [31:0]     hit_mask;
    logic            ack_sel;
    logic [31:0]     rdata_sel;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_mask = '0;
        for (int k = int'(N_SLAVES) - 1; k >= 0; k--) begin
            if ((addr_i & SLAVE_MASK[32*k +: 32]) ==
                (SLAVE_BASE[32*k +: 32] & SLAVE_MASK[32*k +: 32])) begin
                hit      = 1'b1;
                hit_idx  = IdxW'(k);
                hit_mask = SLAVE_MASK[32*k +: 32];
            end
        end
    end

    assign ack_sel   = s_ack_i[idx_q];
    assign rdata_sel = s_rdata_i[32*idx_q +: 32];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    if (hit) begin
                        idx_d   = hit_idx;
                        we_d    = we_i;
                        be_d    = be_i;
                        addr_d  = addr_i & ~hit_mask;
                        wdata_d = wdata_i;
                        cnt_d   = '0;
                        state_d = StAccess;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = DEF_RDATA;
                        state_d = StResp;
                    end
                end
            end
            StAccess: begin
                // Ack is checked first so an ack in the expiry cycle still completes cleanly.
                if (ack_sel) begin
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'h0 : rdata_sel;
                    state_d = StResp;
                end else if (TimeoutEn && (cnt_q == CntW'(TimeoutLast))) begin
                    err_d   = 1'b1;
                    rdata_d = DEF_RDATA;
                    state_d = StResp;
                end else if (TimeoutEn) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        s_req_o = '0;
        if (state_q == StAccess) begin
            s_req_o[idx_q] = 1'b1;
        end
    end

    assign done_o    = (state_q == StResp);
    assign stall_o   = req_i & ~done_o;
    assign err_o     = err_q;
    assign rdata_o   = rdata_q;
    assign s_we_o    = we_q;
    assign s_be_o    = be_q;
    assign s_addr_o  = addr_q;
    assign s_wdata_o = wdata_q;

`ifdef MIRISCV_BUS_ERR_LATCH_EN
    logic        fault;
    logic [31:0] err_addr_q;
    logic [7:0]  err_cnt_q;

    // Captured while the core still holds addr_i, i.e. on the transition into RESP.
    assign fault = (state_d == StResp) && err_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else if (fault) begin
            err_addr_q <= addr_i;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;
`else
    assign err_addr_o = '0;
    assign err_cnt_o  = '0;
`endif

endmodule
